vec_divmod_unit: RTL
====================

# vec_divmod_unit

Iterative SIMD unsigned divide/modulo unit for the vector execute stage. It takes a packed dividend and divisor vector with a lane-width code and computes quotient and remainder for every lane at once, one bit per clock, using restoring division with the carry chain cut at lane boundaries. It replaces the single-cycle VDIV/VMOD path: a single issue slot returns both results, and the unit reports per-lane divide-by-zero. A valid/ready handshake on each side lets the pipeline stall while the unit is busy.

## Interface
- DATA_W, 64, vector width in bits; legal values 64 and 128; lane 0 occupies bits [0:lane_w-1], with bit 0 as MSB.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands.
- ww  in  2  lane width: 00=8, 01=16, 10=32, 11=64 bits.
- rA  in  DATA_W  dividend vector.
- rB  in  DATA_W  divisor vector.
- flush  in  1  synchronous abort; discards the operation in flight.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- q_out  out  DATA_W  per-lane quotient.
- r_out  out  DATA_W  per-lane remainder.
- dbz_mask  out  DATA_W/8  one bit per byte; set for every byte of a lane whose divisor is 0.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→CALC on in_valid&in_ready. ww, rA and rB are latched at this edge. dbz_mask is computed from rB and ww at this edge.
  - CALC→DONE when the iteration counter reaches lane_w-1.
  - DONE→IDLE on out_ready.
  - Any state→IDLE on flush. out_valid drops the next cycle and the results are not presented.
- Each CALC cycle, every lane does the following:
  - Shift its partial remainder left by 1 and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor.
  - If there is no borrow, keep the difference and shift a quotient bit of 1 in; otherwise restore and shift 0 in.
- Borrow and carry never cross lane boundaries. Lanes are fully independent.
- All arithmetic is unsigned and modulo lane width. The remainder is always less than the divisor when the divisor is non-zero.
- Divisor 0 without the macro: the quotient lane is all ones and the remainder lane equals the dividend (the natural restoring result). dbz_mask bits are set.
- ww is ignored while busy. Changes on the input have no effect until the next acceptance.
- q_out, r_out and dbz_mask hold their values from entering DONE until the next acceptance.
- Reset: state=IDLE; in_ready=1 during reset; out_valid=0; q_out=0; r_out=0; dbz_mask=0; counter=0. Reset mid-CALC or mid-DONE discards the operation.

## Timing
- Acceptance edge = E0. out_valid rises after edge E(lane_w): 8, 16, 32 or 64 cycles for ww=00/01/10/11. The latency does not depend on DATA_W.
- There is no overlap. The next acceptance is possible no earlier than the edge after the DONE→IDLE transition, so minimum issue interval = lane_w+2 cycles.
- in_ready is registered state only. It is not combinationally dependent on in_valid.
- out_valid stays high and the outputs stay stable until the edge where out_ready=1.
- flush and out_ready asserted together in DONE: flush wins; the result is dropped and there is no transfer.
- flush in IDLE together with in_valid: flush wins; the operands are not accepted.

## Configuration
- VDIVMOD_DBZ_ZERO_EN defined: any lane with divisor 0 produces quotient 0 and remainder 0. dbz_mask is unchanged.
- Not defined: the natural restoring result applies (quotient all ones, remainder = dividend).
- Latency is identical either way.

## Test plan
- Lane_w 8, DATA_W=64: ww=00, all lanes rA=0xC8, rB=0x07. Required response:
  - out_valid after 8 cycles.
  - every q lane =0x1C, every r lane =0x04.
  - dbz_mask=0x00.
- Lane_w 16: ww=01, lanes rA=0xFFFF, rB=0x0010. Required response:
  - q lanes =0x0FFF, r lanes =0x000F.
  - latency 16 cycles.
- Lane_w 64, and a non-zero-divisor lane next to a zero-divisor lane, without the macro:
  - ww=11, rA=0x64, rB=0x0A → q=0x0A, r=0, latency 64.
  - Then ww=10, rA=0x00000009_00000009, rB=0x00000000_00000002:
    - lane 0 (divisor 0): q=0xFFFFFFFF, r=0x00000009, dbz_mask=0xF0.
    - lane 1: q=4, r=1.
  - With VDIVMOD_DBZ_ZERO_EN, lane 0 becomes q=0, r=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required response:
  - outputs stable.
  - in_ready=0.
  - in_valid ignored.
  - out_ready pulse → in_ready=1 next cycle.
- Abort: flush at CALC cycle 3, and separately rst_n low mid-CALC. Required response:
  - IDLE next cycle.
  - out_valid never asserted.
  - after reset, all outputs are 0.
  - a fresh operation afterwards gives correct results.

Source files
------------

// File: rtl/vec_divmod_if.sv
// rtl/vec_divmod_if.sv - operand/result handshake bundle for vec_divmod_unit
interface vec_divmod_if #(
   parameter int DATA_W = 64
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          ww;
   logic [DATA_W-1:0]   rA;
   logic [DATA_W-1:0]   rB;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   q_out;
   logic [DATA_W-1:0]   r_out;
   logic [DATA_W/8-1:0] dbz_mask;

   modport master (
      output in_valid, ww, rA, rB, flush, out_ready,
      input  in_ready, out_valid, q_out, r_out, dbz_mask
   );

   modport slave (
      input  in_valid, ww, rA, rB, flush, out_ready,
      output in_ready, out_valid, q_out, r_out, dbz_mask
   );
endinterface

// File: rtl/vec_divmod_unit.sv
// rtl/vec_divmod_unit.sv - iterative SIMD unsigned divide/modulo, one quotient bit per clock (option macro: VDIVMOD_DBZ_ZERO_EN)
module vec_divmod_unit #(
   parameter int DATA_W = 64
) (
   input logic         clk,
   input logic         rst_n,
   vec_divmod_if.slave bus
);
   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [1:0]          ww_q;
   logic [5:0]          cnt;
   logic [5:0]          cnt_last;
   logic [DATA_W-1:0]   a_q;      // dividend bits shift out at the top, quotient bits shift in at the bottom
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   rem_q;
   logic [4*DATA_W-1:0] a_all;    // one candidate step per lane width, selected by ww_q
   logic [4*DATA_W-1:0] r_all;
   logic [4*NB-1:0]     dbz_all;
   logic [DATA_W-1:0]   a_step;
   logic [DATA_W-1:0]   r_step;
   logic [NB-1:0]       dbz_in;
   logic                accept;
   logic                last_iter;

   // Per-lane restoring step for every supported lane width; slices never share a borrow chain.
   for (genvar g = 0; g < 4; g++) begin : g_width
      localparam int W  = 8 << g;
      localparam int NL = DATA_W / W;
      for (genvar l = 0; l < NL; l++) begin : g_lane
         logic [W:0] shifted;
         logic [W:0] diff;
         assign shifted = {rem_q[l*W +: W], a_q[l*W + W - 1]};
         assign diff    = shifted - {1'b0, b_q[l*W +: W]};
         assign r_all[g*DATA_W + l*W +: W] = diff[W] ? shifted[W-1:0] : diff[W-1:0];
         assign a_all[g*DATA_W + l*W +: W] = {a_q[l*W +: W-1], ~diff[W]};
         assign dbz_all[g*NB + l*(W/8) +: W/8] = {(W/8){bus.rB[l*W +: W] == '0}};
      end
   end

   // Select the step result and iteration count of the latched lane width.
   always_comb begin
      a_step   = a_all[0 +: DATA_W];
      r_step   = r_all[0 +: DATA_W];
      cnt_last = 6'd7;
      unique case (ww_q)
         2'b00: begin a_step = a_all[0*DATA_W +: DATA_W]; r_step = r_all[0*DATA_W +: DATA_W]; cnt_last = 6'd7;  end
         2'b01: begin a_step = a_all[1*DATA_W +: DATA_W]; r_step = r_all[1*DATA_W +: DATA_W]; cnt_last = 6'd15; end
         2'b10: begin a_step = a_all[2*DATA_W +: DATA_W]; r_step = r_all[2*DATA_W +: DATA_W]; cnt_last = 6'd31; end
         default: begin a_step = a_all[3*DATA_W +: DATA_W]; r_step = r_all[3*DATA_W +: DATA_W]; cnt_last = 6'd63; end
      endcase
   end

   // Divide-by-zero byte mask for the incoming operands, sized by the incoming lane width.
   always_comb begin
      dbz_in = dbz_all[0 +: NB];
      unique case (bus.ww)
         2'b00:   dbz_in = dbz_all[0*NB +: NB];
         2'b01:   dbz_in = dbz_all[1*NB +: NB];
         2'b10:   dbz_in = dbz_all[2*NB +: NB];
         default: dbz_in = dbz_all[3*NB +: NB];
      endcase
   end

`ifdef VDIVMOD_DBZ_ZERO_EN
   logic [DATA_W-1:0] keep;
   for (genvar j = 0; j < NB; j++) begin : g_keep
      assign keep[j*8 +: 8] = {8{~bus.dbz_mask[j]}};
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs; flush overrides every other transition.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      last_iter     = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = CALC;
               accept    = !bus.flush;
            end
         end
         CALC: begin
            if (cnt == cnt_last) begin
               state_nxt = DONE;
               last_iter = !bus.flush;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   // Operand latch, per-cycle iteration and result capture on the final step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ww_q         <= '0;
         cnt          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rem_q        <= '0;
         bus.q_out    <= '0;
         bus.r_out    <= '0;
         bus.dbz_mask <= '0;
      end else begin
         if (accept) begin
            ww_q         <= bus.ww;
            a_q          <= bus.rA;
            b_q          <= bus.rB;
            rem_q        <= '0;
            cnt          <= '0;
            bus.dbz_mask <= dbz_in;
         end else if (state == CALC && !bus.flush) begin
            a_q   <= a_step;
            rem_q <= r_step;
            cnt   <= cnt + 6'd1;
         end
         if (last_iter) begin
`ifdef VDIVMOD_DBZ_ZERO_EN
            bus.q_out <= a_step & keep;
            bus.r_out <= r_step & keep;
`else
            bus.q_out <= a_step;
            bus.r_out <= r_step;
`endif
         end
      end
   end
endmodule
